display_source_ctrl: RTL and testbench

Controller for the 4-digit multiplexed 7-segment display. Two producers share the display: source 0 is keypad entry and source 1 is the arithmetic result. The block arbitrates between them with a valid/ready handshake and latches the winning 16-bit BCD word into four registered digit outputs. Those outputs drive the display multiplexer's `digit0..digit3` inputs. A minimum hold time stops the non-owning source from immediately overwriting a freshly shown value, and optional leading-zero blanking is applied at load time.

---
 rtl/display_source_ctrl.sv | 109 ++++++++++
 tb/tb_display_source_ctrl.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/display_source_ctrl.sv
// Two-source arbiter for the 4-digit 7-segment display.
// Latches the winning BCD word with a hold window and leading-zero blanking.
module display_source_ctrl #(
   parameter int unsigned HOLD_CYCLES = 27_000_000,
   parameter bit          BLANK_LZ    = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        src0_valid,
   input  logic [15:0] src0_data,
   output logic        src0_ready,
   input  logic        src1_valid,
   input  logic [15:0] src1_data,
   output logic        src1_ready,
   output logic [3:0]  digit0,
   output logic [3:0]  digit1,
   output logic [3:0]  digit2,
   output logic [3:0]  digit3,
   output logic [1:0]  owner,
   output logic        busy
);

   localparam int unsigned CW =
      (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LOAD = CW'(HOLD_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_OPEN = 2'd2
   } state_t;

   state_t        state;
   logic [CW-1:0] hold_cnt;
   logic [15:0]   disp;
   logic          acc0;
   logic          acc1;

   function automatic logic [15:0] blank_lz(input logic [15:0] d);
      logic [15:0] r;
      logic        lead;
      r    = d;
      lead = 1'b1;
      if (BLANK_LZ) begin
         for (int i = 3; i >= 1; i--) begin
            if (lead && d[i*4 +: 4] == 4'h0)
               r[i*4 +: 4] = 4'hF;
            else
               lead = 1'b0;
         end
      end
      return r;
   endfunction

   // Readies: owner-only during HOLD, src1 priority otherwise
   always_comb begin
      src0_ready = 1'b0;
      src1_ready = 1'b0;
      if (rst_n && !clear) begin
         if (state == ST_HOLD) begin
            src0_ready = (owner == 2'b01);
            src1_ready = (owner == 2'b10);
         end else begin
            src1_ready = src1_valid;
            src0_ready = !src1_valid;
         end
      end
   end

   assign acc0 = src0_valid && src0_ready;
   assign acc1 = src1_valid && src1_ready;

   assign digit0 = disp[3:0];
   assign digit1 = disp[7:4];
   assign digit2 = disp[11:8];
   assign digit3 = disp[15:12];

   // State, display word, owner and hold counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         disp     <= 16'hFFFF;
         owner    <= 2'b00;
         busy     <= 1'b0;
         hold_cnt <= '0;
      end else if (clear) begin
         state    <= ST_IDLE;
         disp     <= 16'hFFFF;
         owner    <= 2'b00;
         busy     <= 1'b0;
         hold_cnt <= '0;
      end else if (acc0 || acc1) begin
         state    <= ST_HOLD;
         disp     <= blank_lz(acc1 ? src1_data : src0_data);
         owner    <= acc1 ? 2'b10 : 2'b01;
         busy     <= 1'b1;
         hold_cnt <= CNT_LOAD;
      end else if (state == ST_HOLD) begin
         if (hold_cnt == '0) begin
            state <= ST_OPEN;
            busy  <= 1'b0;
         end else begin
            hold_cnt <= hold_cnt - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_display_source_ctrl.sv
// Scoreboard bench for display_source_ctrl.
// Two instances: leading-zero blanking on (A) and off (B).
module tb_display_source_ctrl;

   typedef struct packed {
      logic [15:0] dig;
      logic [1:0]  own;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        clear = 1'b0;
   logic        s0v = 1'b0, s1v = 1'b0;
   logic [15:0] s0d = '0, s1d = '0;
   logic        s0r, s1r;
   logic [3:0]  a0, a1, a2, a3;
   logic [1:0]  a_own;
   logic        a_busy;

   logic        b0v = 1'b0, b1v = 1'b0;
   logic [15:0] b0d = '0, b1d = '0;
   logic        b0r, b1r;
   logic [3:0]  bd0, bd1, bd2, bd3;
   logic [1:0]  b_own;
   logic        b_busy;

   int checks = 0;
   int failures = 0;
   exp_t qa[$];
   exp_t qb[$];
   logic pa = 1'b0, pb = 1'b0;

   always #5 clk = ~clk;

   display_source_ctrl #(.HOLD_CYCLES(4), .BLANK_LZ(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .src0_valid(s0v), .src0_data(s0d), .src0_ready(s0r),
      .src1_valid(s1v), .src1_data(s1d), .src1_ready(s1r),
      .digit0(a0), .digit1(a1), .digit2(a2), .digit3(a3),
      .owner(a_own), .busy(a_busy)
   );

   display_source_ctrl #(.HOLD_CYCLES(4), .BLANK_LZ(1'b0)) dut_b (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .src0_valid(b0v), .src0_data(b0d), .src0_ready(b0r),
      .src1_valid(b1v), .src1_data(b1d), .src1_ready(b1r),
      .digit0(bd0), .digit1(bd1), .digit2(bd2), .digit3(bd3),
      .owner(b_own), .busy(b_busy)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor A: compare outputs on the cycle after each transfer
   always @(negedge clk) begin
      exp_t e;
      if (pa) begin
         if (qa.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_unexpected_xfer digits=%h", {a3, a2, a1, a0});
         end else begin
            e = qa.pop_front();
            chk("a_digits", {16'h0, a3, a2, a1, a0}, {16'h0, e.dig});
            chk("a_owner", {30'h0, a_own}, {30'h0, e.own});
            chk("a_busy", {31'h0, a_busy}, 32'h1);
         end
      end
      pa = rst_n && !clear && ((s0v && s0r) || (s1v && s1r));
   end

   // Monitor B
   always @(negedge clk) begin
      exp_t e;
      if (pb) begin
         if (qb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL b_unexpected_xfer digits=%h", {bd3, bd2, bd1, bd0});
         end else begin
            e = qb.pop_front();
            chk("b_digits", {16'h0, bd3, bd2, bd1, bd0}, {16'h0, e.dig});
            chk("b_owner", {30'h0, b_own}, {30'h0, e.own});
         end
      end
      pb = rst_n && !clear && ((b0v && b0r) || (b1v && b1r));
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      // reset with both valids high
      #1;
      rst_n = 1'b0;
      s0v = 1'b1; s1v = 1'b1;
      s0d = 16'h1234; s1d = 16'h5678;
      #2;
      chk("rst_digits", {16'h0, a3, a2, a1, a0}, 32'hFFFF);
      chk("rst_owner", {30'h0, a_own}, 32'h0);
      chk("rst_busy", {31'h0, a_busy}, 32'h0);
      chk("rst_readies", {30'h0, s0r, s1r}, 32'h0);
      tick();
      s0v = 1'b0; s1v = 1'b0;
      rst_n = 1'b1;
      tick();

      // single load 0x0042, busy window of 4 edges
      s0v = 1'b1; s0d = 16'h0042;
      qa.push_back('{dig: 16'hFF42, own: 2'b01});
      tick();
      s0v = 1'b0;
      chk("hold_busy_n0", {31'h0, a_busy}, 32'h1);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("hold_busy_mid", {31'h0, a_busy}, 32'h1);
      end
      tick();
      chk("open_busy", {31'h0, a_busy}, 32'h0);
      chk("open_owner", {30'h0, a_own}, 32'h1);
      chk("open_digits", {16'h0, a3, a2, a1, a0}, 32'hFF42);

      // all-zero word keeps digit0
      s0v = 1'b1; s0d = 16'h0000;
      qa.push_back('{dig: 16'hFFF0, own: 2'b01});
      tick();
      s0v = 1'b0;

      // clear mid-HOLD with owner valid
      clear = 1'b1;
      s0v = 1'b1; s0d = 16'h1234;
      #1;
      chk("clear_ready0", {31'h0, s0r}, 32'h0);
      tick();
      clear = 1'b0; s0v = 1'b0;
      chk("clear_digits", {16'h0, a3, a2, a1, a0}, 32'hFFFF);
      chk("clear_owner", {30'h0, a_own}, 32'h0);
      chk("clear_busy", {31'h0, a_busy}, 32'h0);
      tick();

      // simultaneous request in IDLE
      s0v = 1'b1; s0d = 16'h1111;
      s1v = 1'b1; s1d = 16'h2222;
      #1;
      chk("sim_ready1", {31'h0, s1r}, 32'h1);
      chk("sim_ready0", {31'h0, s0r}, 32'h0);
      qa.push_back('{dig: 16'h2222, own: 2'b10});
      qa.push_back('{dig: 16'h1111, own: 2'b01});
      tick();
      s1v = 1'b0;
      chk("wait_ready0", {31'h0, s0r}, 32'h0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         chk("wait_ready0", {31'h0, s0r}, 32'h0);
      end
      tick();
      chk("open_ready0", {31'h0, s0r}, 32'h1);
      tick();
      s0v = 1'b0;
      repeat (4) tick();
      chk("sim_open_busy", {31'h0, a_busy}, 32'h0);

      // restart of the hold by the owner
      s1v = 1'b1; s1d = 16'h0005;
      qa.push_back('{dig: 16'hFFF5, own: 2'b10});
      tick();
      s1v = 1'b0;
      tick();
      s1v = 1'b1; s1d = 16'h0007;
      qa.push_back('{dig: 16'hFFF7, own: 2'b10});
      tick();
      s1v = 1'b0;
      tick();
      tick();
      chk("restart_busy_m4", {31'h0, a_busy}, 32'h1);
      tick();
      chk("restart_busy_m5", {31'h0, a_busy}, 32'h1);
      tick();
      chk("restart_busy_m6", {31'h0, a_busy}, 32'h0);
      chk("restart_digits", {16'h0, a3, a2, a1, a0}, 32'hFFF7);

      // async reset mid-HOLD; B shows verbatim 0x0A03
      s1v = 1'b1; s1d = 16'h0009;
      qa.push_back('{dig: 16'hFFF9, own: 2'b10});
      b0v = 1'b1; b0d = 16'h0A03;
      qb.push_back('{dig: 16'h0A03, own: 2'b01});
      tick();
      s1v = 1'b0; b0v = 1'b0;
      tick();
      chk("pre_arst_busy", {31'h0, a_busy}, 32'h1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_a_digits", {16'h0, a3, a2, a1, a0}, 32'hFFFF);
      chk("arst_a_owner", {30'h0, a_own}, 32'h0);
      chk("arst_a_busy", {31'h0, a_busy}, 32'h0);
      chk("arst_b_digits", {16'h0, bd3, bd2, bd1, bd0}, 32'hFFFF);
      chk("arst_b_busy", {31'h0, b_busy}, 32'h0);
      tick();
      rst_n = 1'b1;
      tick();
      tick();
      chk("qa_left", qa.size(), 32'h0);
      chk("qb_left", qb.size(), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
